// File: rtl/fml_wrr_arb.sv
// fml_wrr_arb: four-master weighted round-robin FML arbiter with starvation override
module fml_wrr_arb #(
   parameter int fml_depth = 26,
   parameter logic [5:0] starve_limit = 6'd48
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [fml_depth-1:0] m0_adr,
   input  logic                 m0_stb,
   input  logic                 m0_we,
   output logic                 m0_ack,
   input  logic [7:0]           m0_sel,
   input  logic [63:0]          m0_di,
   output logic [63:0]          m0_do,
   input  logic [fml_depth-1:0] m1_adr,
   input  logic                 m1_stb,
   input  logic                 m1_we,
   output logic                 m1_ack,
   input  logic [7:0]           m1_sel,
   input  logic [63:0]          m1_di,
   output logic [63:0]          m1_do,
   input  logic [fml_depth-1:0] m2_adr,
   input  logic                 m2_stb,
   input  logic                 m2_we,
   output logic                 m2_ack,
   input  logic [7:0]           m2_sel,
   input  logic [63:0]          m2_di,
   output logic [63:0]          m2_do,
   input  logic [fml_depth-1:0] m3_adr,
   input  logic                 m3_stb,
   input  logic                 m3_we,
   output logic                 m3_ack,
   input  logic [7:0]           m3_sel,
   input  logic [63:0]          m3_di,
   output logic [63:0]          m3_do,
   input  logic [15:0]          cfg_weight,
   output logic [fml_depth-1:0] s_adr,
   output logic                 s_stb,
   output logic                 s_we,
   input  logic                 s_ack,
   output logic [7:0]           s_sel,
   input  logic [63:0]          s_di,
   output logic [63:0]          s_do,
   output logic [1:0]           owner,
   output logic                 busy
);
   typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;
   state_t               state_q, state_d;
   logic                 s_stb_q, s_stb_d, s_we_q, s_we_d;
   logic [fml_depth-1:0] s_adr_q, s_adr_d;
   logic [1:0]           owner_q, owner_d, cnt_q, cnt_d, rr_ptr_q, rr_ptr_d;
   logic [3:0]           credit_q [4];
   logic [3:0]           credit_d [4];
   logic [5:0]           age_q [4];
   logic [5:0]           age_d [4];
   logic [3:0]           cr [4];
   logic [fml_depth-1:0] adr [4];
   logic [3:0]           stb, we, ack;
   logic                 reload, found, arb;
   logic [1:0]           win, idx;

   assign stb    = {m3_stb, m2_stb, m1_stb, m0_stb};
   assign we     = {m3_we, m2_we, m1_we, m0_we};
   assign adr[0] = m0_adr;
   assign adr[1] = m1_adr;
   assign adr[2] = m2_adr;
   assign adr[3] = m3_adr;
   assign arb    = state_q == IDLE && stb != 4'd0;
   assign ack    = (state_q == REQ && s_ack) ? 4'b0001 << owner_q : 4'd0;
   assign {m3_ack, m2_ack, m1_ack, m0_ack} = ack;
   assign m0_do  = s_di;
   assign m1_do  = s_di;
   assign m2_do  = s_di;
   assign m3_do  = s_di;
   assign s_do   = owner_q == 2'd0 ? m0_di : owner_q == 2'd1 ? m1_di : owner_q == 2'd2 ? m2_di : m3_di;
   assign s_sel  = owner_q == 2'd0 ? m0_sel : owner_q == 2'd1 ? m1_sel : owner_q == 2'd2 ? m2_sel : m3_sel;
   assign s_adr  = s_adr_q;
   assign s_stb  = s_stb_q;
   assign s_we   = s_we_q;
   assign owner  = owner_q;
   assign busy   = state_q != IDLE;

   // winner selection: reload credits when no requester has any left, starved masters override WRR
   always_comb begin
      reload = 1'b1;
      for (int i = 0; i < 4; i++)
         if (stb[i] && credit_q[i] != 4'd0) reload = 1'b0;
      for (int i = 0; i < 4; i++)
         cr[i] = reload ? (cfg_weight[4*i+:4] == 4'd0 ? 4'd1 : cfg_weight[4*i+:4]) : credit_q[i];
      win   = rr_ptr_q;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr_q + 2'(k);
         if (!found && stb[idx] && cr[idx] != 4'd0) begin
            win   = idx;
            found = 1'b1;
         end
      end
      for (int i = 3; i >= 0; i--)
         if (stb[i] && age_q[i] == starve_limit) win = 2'(i);
   end

   // bus FSM: arbitrate in IDLE, hold the request until s_ack, then count the remaining three beats
   always_comb begin
      state_d  = state_q;
      s_stb_d  = s_stb_q;
      s_we_d   = s_we_q;
      s_adr_d  = s_adr_q;
      owner_d  = owner_q;
      cnt_d    = 2'd0;
      rr_ptr_d = rr_ptr_q;
      credit_d = credit_q;
      case (state_q)
         IDLE: if (arb) begin
            state_d       = REQ;
            s_stb_d       = 1'b1;
            s_adr_d       = adr[win];
            s_we_d        = we[win];
            owner_d       = win;
            credit_d      = cr;
            credit_d[win] = cr[win] - 4'(cr[win] != 4'd0);
            rr_ptr_d      = credit_d[win] != 4'd0 ? win : win + 2'd1;
         end
         REQ: if (s_ack) begin
            state_d = BURST;
            s_stb_d = 1'b0;
         end
         BURST: begin
            cnt_d   = cnt_q == 2'd2 ? 2'd0 : cnt_q + 2'd1;
            state_d = cnt_q == 2'd2 ? IDLE : BURST;
         end
         default: state_d = IDLE;
      endcase
   end

   // starvation ages: a master being granted or served in REQ is not waiting
   always_comb begin
      for (int i = 0; i < 4; i++)
         age_d[i] = (!stb[i] || (arb && win == 2'(i)) || (state_q == REQ && owner_q == 2'(i))) ? 6'd0 :
                    age_q[i] == starve_limit ? age_q[i] : age_q[i] + 6'd1;
   end

   // state registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= IDLE;
         s_stb_q  <= 1'b0;
         s_we_q   <= 1'b0;
         s_adr_q  <= '0;
         owner_q  <= 2'd0;
         cnt_q    <= 2'd0;
         rr_ptr_q <= 2'd0;
         credit_q <= '{default: 4'd0};
         age_q    <= '{default: 6'd0};
      end else begin
         state_q  <= state_d;
         s_stb_q  <= s_stb_d;
         s_we_q   <= s_we_d;
         s_adr_q  <= s_adr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         credit_q <= credit_d;
         age_q    <= age_d;
      end
   end
endmodule

// File: tb/tb_fml_wrr_arb.sv
// tb_fml_wrr_arb: directed and randomized checks of fml_wrr_arb against a behavioural model
module tb_fml_wrr_arb;
   localparam int FD = 26;
   logic clk = 1'b0, rst = 1'b0, s_ack = 1'b0;
   logic [3:0] stb = '0, we = '0;
   logic [FD-1:0] adr [4];
   logic [7:0] sel [4];
   logic [63:0] di [4];
   logic [15:0] cfg_weight = '0;
   logic [63:0] s_di = '0;
   logic [FD-1:0] a_adr, b_adr;
   logic a_sstb, b_sstb, a_we, b_we, a_busy, b_busy;
   logic [1:0] a_own, b_own;
   logic [7:0] a_sel, b_sel;
   logic [63:0] a_sdo, b_sdo;
   logic [3:0] a_ack, b_ack;
   logic [63:0] a_mdo [4];
   logic [63:0] b_mdo [4];
   int tsel = 0, checks = 0, failures = 0;
   int m_phase, m_left, m_owner, m_rr, m_limit;
   int m_credit [4];
   int m_age [4];
   logic [FD-1:0] m_sadr;
   logic m_swe;
   int grants [$];

   wire [FD-1:0] cur_adr  = tsel != 0 ? b_adr : a_adr;
   wire          cur_sstb = tsel != 0 ? b_sstb : a_sstb;
   wire          cur_we   = tsel != 0 ? b_we : a_we;
   wire          cur_busy = tsel != 0 ? b_busy : a_busy;
   wire [1:0]    cur_own  = tsel != 0 ? b_own : a_own;
   wire [7:0]    cur_sel  = tsel != 0 ? b_sel : a_sel;
   wire [63:0]   cur_sdo  = tsel != 0 ? b_sdo : a_sdo;
   wire [3:0]    cur_ack  = tsel != 0 ? b_ack : a_ack;

   always #5 clk = ~clk;

   fml_wrr_arb #(.fml_depth(FD)) dut_a (
      .sys_clk(clk), .sys_rst(rst),
      .m0_adr(adr[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_ack(a_ack[0]), .m0_sel(sel[0]), .m0_di(di[0]), .m0_do(a_mdo[0]),
      .m1_adr(adr[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_ack(a_ack[1]), .m1_sel(sel[1]), .m1_di(di[1]), .m1_do(a_mdo[1]),
      .m2_adr(adr[2]), .m2_stb(stb[2]), .m2_we(we[2]), .m2_ack(a_ack[2]), .m2_sel(sel[2]), .m2_di(di[2]), .m2_do(a_mdo[2]),
      .m3_adr(adr[3]), .m3_stb(stb[3]), .m3_we(we[3]), .m3_ack(a_ack[3]), .m3_sel(sel[3]), .m3_di(di[3]), .m3_do(a_mdo[3]),
      .cfg_weight(cfg_weight), .s_adr(a_adr), .s_stb(a_sstb), .s_we(a_we), .s_ack(s_ack), .s_sel(a_sel),
      .s_di(s_di), .s_do(a_sdo), .owner(a_own), .busy(a_busy));

   fml_wrr_arb #(.fml_depth(FD), .starve_limit(6'd8)) dut_b (
      .sys_clk(clk), .sys_rst(rst),
      .m0_adr(adr[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_ack(b_ack[0]), .m0_sel(sel[0]), .m0_di(di[0]), .m0_do(b_mdo[0]),
      .m1_adr(adr[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_ack(b_ack[1]), .m1_sel(sel[1]), .m1_di(di[1]), .m1_do(b_mdo[1]),
      .m2_adr(adr[2]), .m2_stb(stb[2]), .m2_we(we[2]), .m2_ack(b_ack[2]), .m2_sel(sel[2]), .m2_di(di[2]), .m2_do(b_mdo[2]),
      .m3_adr(adr[3]), .m3_stb(stb[3]), .m3_we(we[3]), .m3_ack(b_ack[3]), .m3_sel(sel[3]), .m3_di(di[3]), .m3_do(b_mdo[3]),
      .cfg_weight(cfg_weight), .s_adr(b_adr), .s_stb(b_sstb), .s_we(b_we), .s_ack(s_ack), .s_sel(b_sel),
      .s_di(s_di), .s_do(b_sdo), .owner(b_own), .busy(b_busy));

   function automatic int eff(int i);
      logic [3:0] w;
      w = cfg_weight[4*i+:4];
      return w == 4'd0 ? 1 : int'(w);
   endfunction

   task automatic model_update();
      int w, op, oo;
      bit rl;
      w  = -1;
      op = m_phase;
      oo = m_owner;
      if (rst) begin
         m_phase = 0; m_left = 0; m_owner = 0; m_rr = 0; m_sadr = '0; m_swe = 1'b0;
         for (int i = 0; i < 4; i++) begin m_credit[i] = 0; m_age[i] = 0; end
         return;
      end
      if (m_phase == 0 && stb != 4'd0) begin
         rl = 1'b1;
         for (int i = 0; i < 4; i++) if (stb[i] && m_credit[i] > 0) rl = 1'b0;
         if (rl) for (int i = 0; i < 4; i++) m_credit[i] = eff(i);
         for (int i = 3; i >= 0; i--) if (stb[i] && m_age[i] == m_limit) w = i;
         for (int j = 0; j < 4; j++) if (w < 0 && stb[(m_rr + j) % 4] && m_credit[(m_rr + j) % 4] > 0) w = (m_rr + j) % 4;
         if (m_credit[w] > 0) m_credit[w]--;
         m_rr = m_credit[w] > 0 ? w : (w + 1) % 4;
         m_owner = w; m_sadr = adr[w]; m_swe = we[w]; m_phase = 1;
      end else if (m_phase == 1) begin
         if (s_ack) begin m_phase = 2; m_left = 3; end
      end else if (m_phase == 2) begin
         m_left--;
         if (m_left == 0) m_phase = 0;
      end
      for (int i = 0; i < 4; i++)
         m_age[i] = (!stb[i] || i == w || (op == 1 && oo == i)) ? 0 : (m_age[i] < m_limit ? m_age[i] + 1 : m_age[i]);
   endtask

   task automatic adv();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int s);
      tsel = s;
      m_limit = s != 0 ? 8 : 48;
      stb = '0; we = '0; s_ack = 1'b0; rst = 1'b1;
      for (int i = 0; i < 4; i++) begin adr[i] = FD'($urandom); sel[i] = 8'($urandom); di[i] = {$urandom, $urandom}; end
      repeat (2) begin @(negedge clk); adv(); end
      rst = 1'b0;
   endtask

   task automatic run_grants(input int n, input int delay);
      int hi;
      bit prev;
      hi = 0;
      prev = cur_sstb;
      grants.delete();
      for (int c = 0; c < 300 && grants.size() < n; c++) begin
         hi = cur_sstb ? hi + 1 : 0;
         s_ack = cur_sstb && hi >= delay;
         @(negedge clk);
         if (cur_sstb && !prev) grants.push_back(int'(cur_own));
         prev = cur_sstb;
         adv();
      end
   endtask

   task automatic test_reset();
      tsel = 0;
      m_limit = 48;
      rst = 1'b1; s_ack = 1'b1; stb = 4'hF;
      for (int i = 0; i < 4; i++) begin adr[i] = FD'($urandom); we[i] = 1'b1; end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c > 0) begin
            checks += 6;
            if ({a_sstb, a_we, a_busy} !== 3'b000) begin failures++; $display("FAIL reset_a_ctl got=%b exp=000", {a_sstb, a_we, a_busy}); end
            if ({b_sstb, b_we, b_busy} !== 3'b000) begin failures++; $display("FAIL reset_b_ctl got=%b exp=000", {b_sstb, b_we, b_busy}); end
            if (a_adr !== '0 || b_adr !== '0) begin failures++; $display("FAIL reset_adr got=%h/%h exp=0", a_adr, b_adr); end
            if (a_own !== 2'd0 || b_own !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d/%0d exp=0", a_own, b_own); end
            if (a_ack !== 4'd0) begin failures++; $display("FAIL reset_a_ack got=%b exp=0000", a_ack); end
            if (b_ack !== 4'd0) begin failures++; $display("FAIL reset_b_ack got=%b exp=0000", b_ack); end
         end
         adv();
      end
      rst = 1'b0; stb = '0; s_ack = 1'b0; we = '0;
   endtask

   task automatic test_single_read();
      do_reset(0);
      cfg_weight = 16'h1111;
      we[1] = 1'b0;
      for (int c = 0; c < 9; c++) begin
         stb[1] = c <= 3;
         s_ack = c == 3;
         @(negedge clk);
         checks += 3;
         if (cur_sstb !== (c >= 1 && c <= 3)) begin failures++; $display("FAIL single_stb c=%0d got=%b exp=%b", c, cur_sstb, c >= 1 && c <= 3); end
         if (cur_ack !== (c == 3 ? 4'b0010 : 4'b0000)) begin failures++; $display("FAIL single_ack c=%0d got=%b", c, cur_ack); end
         if (cur_busy !== (c >= 1 && c <= 6)) begin failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, cur_busy, c >= 1 && c <= 6); end
         if (c >= 1 && c <= 3) begin
            checks++;
            if (cur_adr !== adr[1]) begin failures++; $display("FAIL single_adr c=%0d got=%h exp=%h", c, cur_adr, adr[1]); end
         end
         adv();
      end
   endtask

   task automatic test_wrr_order();
      int e [8] = '{0, 0, 1, 2, 3, 0, 0, 1};
      do_reset(0);
      cfg_weight = 16'h1112;
      stb = 4'hF;
      run_grants(8, 1);
      checks++;
      if (grants.size() != 8) begin failures++; $display("FAIL wrr_count got=%0d exp=8", grants.size()); end
      for (int i = 0; i < grants.size(); i++) begin
         checks++;
         if (grants[i] != e[i]) begin failures++; $display("FAIL wrr_grant%0d got=%0d exp=%0d", i, grants[i], e[i]); end
      end
   endtask

   task automatic test_zero_weight();
      do_reset(0);
      cfg_weight = 16'h0000;
      stb = 4'b0011;
      run_grants(4, 1);
      checks++;
      if (grants.size() != 4) begin failures++; $display("FAIL zero_count got=%0d exp=4", grants.size()); end
      for (int i = 0; i < grants.size(); i++) begin
         checks++;
         if (grants[i] != i % 2) begin failures++; $display("FAIL zero_grant%0d got=%0d exp=%0d", i, grants[i], i % 2); end
      end
   endtask

   task automatic test_starve();
      do_reset(1);
      cfg_weight = 16'h111F;
      stb = 4'b1001;
      run_grants(2, 10);
      checks++;
      if (grants.size() != 2) begin failures++; $display("FAIL starve_count got=%0d exp=2", grants.size()); end
      for (int i = 0; i < grants.size(); i++) begin
         checks++;
         if (grants[i] != (i == 0 ? 0 : 3)) begin failures++; $display("FAIL starve_grant%0d got=%0d exp=%0d", i, grants[i], i == 0 ? 0 : 3); end
      end
   endtask

   task automatic test_write_mux();
      do_reset(0);
      cfg_weight = 16'h1111;
      we[2] = 1'b1;
      we[0] = 1'b0;
      di[0] = ~di[2];
      sel[0] = ~sel[2];
      for (int c = 0; c < 7; c++) begin
         stb[2] = c <= 1;
         stb[0] = c >= 2;
         s_ack = cur_sstb;
         @(negedge clk);
         if (c >= 1 && c <= 4) begin
            checks += 2;
            if (cur_sdo !== di[2]) begin failures++; $display("FAIL wmux_do c=%0d got=%h exp=%h", c, cur_sdo, di[2]); end
            if (cur_sel !== sel[2]) begin failures++; $display("FAIL wmux_sel c=%0d got=%h exp=%h", c, cur_sel, sel[2]); end
         end
         if (c == 1) begin
            checks += 2;
            if (cur_ack !== 4'b0100) begin failures++; $display("FAIL wmux_ack got=%b exp=0100", cur_ack); end
            if (cur_we !== 1'b1) begin failures++; $display("FAIL wmux_we got=%b exp=1", cur_we); end
         end
         if (c == 6) begin
            checks += 2;
            if (cur_sstb !== 1'b1) begin failures++; $display("FAIL wmux_next_stb got=%b exp=1", cur_sstb); end
            if (cur_own !== 2'd0) begin failures++; $display("FAIL wmux_next_owner got=%0d exp=0", cur_own); end
         end
         adv();
      end
   endtask

   task automatic test_reset_in_burst();
      do_reset(0);
      cfg_weight = 16'h1111;
      for (int c = 0; c < 6; c++) begin
         stb[1] = c <= 1;
         stb[2] = c >= 2;
         s_ack = c == 1 || c == 4;
         rst = c == 3;
         @(negedge clk);
         if (c == 3) begin
            checks++;
            if (cur_busy !== 1'b1) begin failures++; $display("FAIL rstb_busy_before got=%b exp=1", cur_busy); end
         end
         if (c == 4) begin
            checks += 3;
            if (cur_busy !== 1'b0) begin failures++; $display("FAIL rstb_busy got=%b exp=0", cur_busy); end
            if (cur_sstb !== 1'b0) begin failures++; $display("FAIL rstb_stb got=%b exp=0", cur_sstb); end
            if (cur_ack !== 4'd0) begin failures++; $display("FAIL rstb_ack got=%b exp=0000", cur_ack); end
         end
         if (c == 5) begin
            checks += 2;
            if (cur_sstb !== 1'b1) begin failures++; $display("FAIL rstb_regrant_stb got=%b exp=1", cur_sstb); end
            if (cur_own !== 2'd2) begin failures++; $display("FAIL rstb_regrant_owner got=%0d exp=2", cur_own); end
         end
         adv();
      end
      rst = 1'b0;
   endtask

   task automatic test_random(input int s, input int ncyc);
      logic [3:0] ackd, ea;
      ackd = '0;
      do_reset(s);
      cfg_weight = 16'($urandom);
      for (int c = 0; c < ncyc; c++) begin
         rst = $urandom_range(0, 99) == 0;
         if ($urandom_range(0, 49) == 0) cfg_weight = 16'($urandom);
         for (int i = 0; i < 4; i++) begin
            if (ackd[i] && $urandom_range(0, 1) == 0) stb[i] = 1'b0;
            if ((ackd[i] && stb[i]) || (!stb[i] && $urandom_range(0, 2) == 0)) begin
               stb[i] = 1'b1; adr[i] = FD'($urandom); we[i] = 1'($urandom);
               sel[i] = 8'($urandom); di[i] = {$urandom, $urandom};
            end
         end
         s_ack = $urandom_range(0, 2) == 0;
         s_di = {$urandom, $urandom};
         @(negedge clk);
         ea = (m_phase == 1 && s_ack) ? 4'b0001 << m_owner : 4'd0;
         checks += 6;
         if (cur_sstb !== (m_phase == 1)) begin failures++; $display("FAIL rnd_stb c=%0d got=%b exp=%b", c, cur_sstb, m_phase == 1); end
         if (cur_busy !== (m_phase != 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, cur_busy, m_phase != 0); end
         if (cur_own !== 2'(m_owner)) begin failures++; $display("FAIL rnd_owner c=%0d got=%0d exp=%0d", c, cur_own, m_owner); end
         if (cur_adr !== m_sadr) begin failures++; $display("FAIL rnd_adr c=%0d got=%h exp=%h", c, cur_adr, m_sadr); end
         if (cur_we !== m_swe) begin failures++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, cur_we, m_swe); end
         if (cur_ack !== ea) begin failures++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, cur_ack, ea); end
         if (m_phase == 2 || ea != 4'd0) begin
            checks += 2;
            if (cur_sdo !== di[m_owner]) begin failures++; $display("FAIL rnd_sdo c=%0d got=%h exp=%h", c, cur_sdo, di[m_owner]); end
            if (cur_sel !== sel[m_owner]) begin failures++; $display("FAIL rnd_ssel c=%0d got=%h exp=%h", c, cur_sel, sel[m_owner]); end
         end
         for (int k = 0; k < 4; k++) begin
            checks++;
            if ((s != 0 ? b_mdo[k] : a_mdo[k]) !== s_di) begin failures++; $display("FAIL rnd_mdo%0d c=%0d exp=%h", k, c, s_di); end
         end
         ackd = cur_ack;
         adv();
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin adr[i] = '0; sel[i] = '0; di[i] = '0; end
      test_reset();
      test_single_read();
      test_wrr_order();
      test_zero_weight();
      test_starve();
      test_write_mux();
      test_reset_in_burst();
      test_random(0, 600);
      test_random(1, 600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
